bcd_countdown: RTL

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

---
 rtl/bcd_pkg.sv | 31 +++
 rtl/bcd_digit_dn.sv | 27 ++
 rtl/bcd_countdown.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Latency: n/a (types, constants and a combinational decode function).
// Backpressure: n/a.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Segment patterns {g,f,e,d,c,b,a}, active-high, indexed by digit value.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Non-BCD codes blank the digit rather than index past the table.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = 7'h00;
        if (digit <= BCD_MAX) begin
            seg = SEG_TABLE[digit];
        end
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD digit of the down-counter: applies an incoming borrow to the digit.
// Latency: purely combinational.
// Backpressure: none; the borrow ripples straight to the next digit.
module bcd_digit_dn
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] digit_nxt,
    output logic       borrow_out
);

    // A borrow into a zero digit wraps it to 9 and passes the borrow upward.
    always_comb begin
        digit_nxt  = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                digit_nxt  = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_nxt = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// Multi-digit BCD countdown timer with prescaler and multiplexed 7-segment drive.
// Latency: count steps PRESCALE cycles after start; seg/dig_sel lag bcd_out by 1 cycle.
// Backpressure: none; load/start/stop are level-sampled every cycle.
module bcd_countdown
    import bcd_pkg::*;
#(
    parameter int NDIGITS  = 2,
    parameter int PRESCALE = 1000,
    parameter int SCAN     = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   load_val,
    input  logic                   start,
    input  logic                   stop,
    output logic [4*NDIGITS-1:0]   bcd_out,
    output logic                   running,
    output logic                   done,
    output logic                   zero,
    output logic [6:0]             seg,
    output logic [NDIGITS-1:0]     dig_sel
);

    localparam int PW   = $clog2(PRESCALE);
    localparam int SW   = $clog2(SCAN);
    localparam int SELW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [PW-1:0]   PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0]   SCAN_LAST = SW'(SCAN - 1);
    localparam logic [SELW-1:0] SEL_LAST  = SELW'(NDIGITS - 1);

    state_e                 state_q, state_d;
    logic [4*NDIGITS-1:0]   count_q, count_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic                   done_q, done_d;
    logic [SW-1:0]          scan_q, scan_d;
    logic [SELW-1:0]        sel_q, sel_d;
    logic [6:0]             seg_q, seg_d;
    logic [NDIGITS-1:0]     dig_sel_q, dig_sel_d;

    logic [4*NDIGITS-1:0]   count_dec;
    logic [4*NDIGITS-1:0]   load_clamped;
    logic [NDIGITS:0]       borrow;

    // Borrow chain: the top borrow-out is set only when the count is already zero.
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
        bcd_digit_dn u_digit (
            .digit      (count_q[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .digit_nxt  (count_dec[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    // Saturate any non-BCD preset digit to 9.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            load_clamped[4*i +: 4] = (load_val[4*i +: 4] > BCD_MAX) ? BCD_MAX
                                                                    : load_val[4*i +: 4];
        end
    end

    // Control FSM: load beats stop beats start; prescaler drives the decrement.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = load_clamped;
            pre_d   = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stop && start) begin
                        if (count_q == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                            pre_d   = '0;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (!borrow[NDIGITS]) begin
                            count_d = count_dec;
                            if (count_dec == '0) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (!stop && start) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = DONE;
                end
            endcase
        end
    end

    // Display scan: free-running slot counter, registered segment/digit drive.
    always_comb begin
        scan_d = scan_q + 1'b1;
        sel_d  = sel_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end
        seg_d     = seg_decode(count_q[{sel_q, 2'b00} +: 4]);
        dig_sel_d = NDIGITS'(1) << sel_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pre_q     <= '0;
            done_q    <= 1'b0;
            scan_q    <= '0;
            sel_q     <= '0;
            seg_q     <= 7'h3F;
            dig_sel_q <= NDIGITS'(1);
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
            done_q    <= done_d;
            scan_q    <= scan_d;
            sel_q     <= sel_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign bcd_out = count_q;
    assign running = (state_q == RUN);
    assign done    = done_q;
    assign zero    = (count_q == '0);
    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule
